// File: rtl/mul_pkg.sv
// Shared types and helpers for the multiplier issue controller.
package mul_pkg;

    localparam int MUL_XLEN = 32;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_ABORT = 3'd4
    } issue_state_e;

    // MUL returns the low word; every high-word variant returns the upper half.
    function automatic logic [MUL_XLEN-1:0] sel_result(
        input mul_op_e                 op,
        input logic [2*MUL_XLEN-1:0]   product
    );
        logic [MUL_XLEN-1:0] res;
        if (op == OP_MUL) begin
            res = product[MUL_XLEN-1:0];
        end else begin
            res = product[2*MUL_XLEN-1:MUL_XLEN];
        end
        return res;
    endfunction

endpackage

// File: rtl/mul_reuse_cache.sv
// One-entry product cache: remembers the last completed multiply so that a
// MUL/MULH pair on the same operands can skip the second multiplier run.
module mul_reuse_cache
    import mul_pkg::*;
#(
    parameter int XLEN = MUL_XLEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   i_lookup_a,
    input  logic [XLEN-1:0]   i_lookup_b,
    input  logic [1:0]        i_lookup_op,
    output logic              o_hit,
    output logic [2*XLEN-1:0] o_product,
    input  logic              i_wr_en,
    input  logic [XLEN-1:0]   i_wr_a,
    input  logic [XLEN-1:0]   i_wr_b,
    input  logic [1:0]        i_wr_op,
    input  logic [2*XLEN-1:0] i_wr_product,
    input  logic              i_inv
);

    logic              r_valid;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [1:0]        r_op;
    logic [2*XLEN-1:0] r_product;

    // Entry update: reset and invalidate drop the entry, a write replaces it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_a       <= {XLEN{1'b0}};
            r_b       <= {XLEN{1'b0}};
            r_op      <= 2'b00;
            r_product <= {(2*XLEN){1'b0}};
        end else if (i_inv) begin
            r_valid <= 1'b0;
        end else if (i_wr_en) begin
            r_valid   <= 1'b1;
            r_a       <= i_wr_a;
            r_b       <= i_wr_b;
            r_op      <= i_wr_op;
            r_product <= i_wr_product;
        end else begin
            r_valid <= r_valid;
        end
    end

    // Hit when operands match and either the request is MUL (low word does
    // not depend on signedness) or the opcode matches the stored one.
    always_comb begin
        o_hit = 1'b0;
        if (r_valid && (i_lookup_a == r_a) && (i_lookup_b == r_b) &&
            ((i_lookup_op == OP_MUL) || (i_lookup_op == r_op))) begin
            o_hit = 1'b1;
        end else begin
            o_hit = 1'b0;
        end
    end

    assign o_product = r_product;

endmodule

// File: rtl/mul_issue_ctrl.sv
// Pipeline-side start/done initiator for the iterative multiplier, with
// front-end stall, flush/abort handling, timeout and product reuse.
module mul_issue_ctrl
    import mul_pkg::*;
#(
    parameter int XLEN    = MUL_XLEN,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mul_valid_e,
    input  logic [1:0]        mul_opcode_e,
    input  logic [XLEN-1:0]   operand1_e,
    input  logic [XLEN-1:0]   operand2_e,
    input  logic              flush,
    output logic              stall_o,
    output logic              start,
    output logic [XLEN-1:0]   mul_a,
    output logic [XLEN-1:0]   mul_b,
    output logic [1:0]        mul_op,
    input  logic              done,
    input  logic [2*XLEN-1:0] result_multiply,
    output logic [XLEN-1:0]   result_m,
    output logic              flag_m,
    output logic              timeout_err
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    issue_state_e      r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_start;
    logic              r_flag_m;
    logic              r_timeout_err;
    logic [XLEN-1:0]   r_mul_a;
    logic [XLEN-1:0]   r_mul_b;
    logic [1:0]        r_mul_op;
    logic [XLEN-1:0]   r_result_m;

    logic              w_accept;
    logic              w_hit;
    logic [2*XLEN-1:0] w_cache_prod;
    logic              w_cache_wr;
    logic              w_cache_inv;
    logic              w_stall;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_cnt_expired;

    assign w_accept      = (r_state == ST_IDLE) && mul_valid_e && !flush;
    assign w_cnt_inc     = r_cnt + CNT_W'(1);
    assign w_cnt_expired = (w_cnt_inc == TIMEOUT_C);

    mul_reuse_cache #(.XLEN(XLEN)) u_cache (
        .clk          (clk),
        .rst          (rst),
        .i_lookup_a   (operand1_e),
        .i_lookup_b   (operand2_e),
        .i_lookup_op  (mul_opcode_e),
        .o_hit        (w_hit),
        .o_product    (w_cache_prod),
        .i_wr_en      (w_cache_wr),
        .i_wr_a       (r_mul_a),
        .i_wr_b       (r_mul_b),
        .i_wr_op      (r_mul_op),
        .i_wr_product (result_multiply),
        .i_inv        (w_cache_inv)
    );

    // Cache write on a clean completion; invalidate when a wait times out.
    always_comb begin
        w_cache_wr  = 1'b0;
        w_cache_inv = 1'b0;
        if (rst) begin
            w_cache_wr  = 1'b0;
            w_cache_inv = 1'b0;
        end else if ((r_state == ST_ISSUE) || (r_state == ST_WAIT)) begin
            w_cache_wr  = done && !flush;
            w_cache_inv = (r_state == ST_WAIT) && !done && w_cnt_expired;
        end else if (r_state == ST_ABORT) begin
            w_cache_inv = !done && w_cnt_expired;
        end else begin
            w_cache_wr  = 1'b0;
            w_cache_inv = 1'b0;
        end
    end

    // Front-end stall; in ABORT only hold the pipe if a multiply is waiting.
    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            ST_IDLE:  w_stall = w_accept;
            ST_ISSUE: w_stall = 1'b1;
            ST_WAIT:  w_stall = 1'b1;
            ST_DRAIN: w_stall = 1'b0;
            ST_ABORT: w_stall = mul_valid_e;
            default:  w_stall = 1'b0;
        endcase
    end

    assign stall_o = w_stall && !rst;

    // Issue FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= {CNT_W{1'b0}};
            r_start       <= 1'b0;
            r_flag_m      <= 1'b0;
            r_timeout_err <= 1'b0;
            r_mul_a       <= {XLEN{1'b0}};
            r_mul_b       <= {XLEN{1'b0}};
            r_mul_op      <= 2'b00;
            r_result_m    <= {XLEN{1'b0}};
        end else begin
            r_start  <= 1'b0;
            r_flag_m <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_mul_a  <= operand1_e;
                        r_mul_b  <= operand2_e;
                        r_mul_op <= mul_opcode_e;
                        if (w_hit) begin
                            r_result_m <= sel_result(mul_op_e'(mul_opcode_e), w_cache_prod);
                            r_flag_m   <= 1'b1;
                            r_state    <= ST_DRAIN;
                        end else begin
                            r_start <= 1'b1;
                            r_state <= ST_ISSUE;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    r_cnt <= {CNT_W{1'b0}};
                    if (flush) begin
                        r_state <= ST_IDLE;
                    end else if (done) begin
                        r_result_m <= sel_result(mul_op_e'(r_mul_op), result_multiply);
                        r_flag_m   <= 1'b1;
                        r_state    <= ST_DRAIN;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= w_cnt_inc;
                    if (done && flush) begin
                        r_state <= ST_IDLE;
                    end else if (done) begin
                        r_result_m <= sel_result(mul_op_e'(r_mul_op), result_multiply);
                        r_flag_m   <= 1'b1;
                        r_state    <= ST_DRAIN;
                    end else if (w_cnt_expired) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= ST_IDLE;
                    end else if (flush) begin
                        r_state <= ST_ABORT;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_DRAIN: begin
                    r_state <= ST_IDLE;
                end
                ST_ABORT: begin
                    r_cnt <= w_cnt_inc;
                    if (done) begin
                        r_state <= ST_IDLE;
                    end else if (w_cnt_expired) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_state <= ST_ABORT;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign start       = r_start;
    // A flush landing in the DRAIN cycle kills the result hand-off.
    assign flag_m      = r_flag_m && !flush;
    assign timeout_err = r_timeout_err;
    assign mul_a       = r_mul_a;
    assign mul_b       = r_mul_b;
    assign mul_op      = r_mul_op;
    assign result_m    = r_result_m;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Self-checking bench for mul_issue_ctrl: table-driven transactions with a
// result scoreboard plus hand-written flush, abort, timeout and reset cases.
module tb_mul_issue_ctrl;
    import mul_pkg::*;

    logic        clk;
    logic        rst;
    logic        mul_valid_e;
    logic [1:0]  mul_opcode_e;
    logic [31:0] operand1_e;
    logic [31:0] operand2_e;
    logic        flush;
    logic        stall_o;
    logic        start;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [1:0]  mul_op;
    logic        done;
    logic [63:0] result_multiply;
    logic [31:0] result_m;
    logic        flag_m;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb_q[$];

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] prod;
        int          dly;
        bit          hit;
        logic [31:0] res;
    } vec_t;

    vec_t vecs[7];

    mul_issue_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .mul_valid_e     (mul_valid_e),
        .mul_opcode_e    (mul_opcode_e),
        .operand1_e      (operand1_e),
        .operand2_e      (operand2_e),
        .flush           (flush),
        .stall_o         (stall_o),
        .start           (start),
        .mul_a           (mul_a),
        .mul_b           (mul_b),
        .mul_op          (mul_op),
        .done            (done),
        .result_multiply (result_multiply),
        .result_m        (result_m),
        .flag_m          (flag_m),
        .timeout_err     (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic fl, input logic dn,
                         input logic [63:0] p);
        mul_valid_e     = v;
        mul_opcode_e    = op;
        operand1_e      = a;
        operand2_e      = b;
        flush           = fl;
        done            = dn;
        result_multiply = p;
    endtask

    task automatic idle_in();
        drive(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 64'd0);
    endtask

    // Let inputs settle, then pop the scoreboard on every flag_m.
    task automatic settle();
        #1;
        if (flag_m === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_flag: flag_m=1 result_m=0x%0h, no result expected", result_m);
            end else begin
                chk("sb_result", {32'd0, result_m}, {32'd0, sb_q.pop_front()});
            end
        end
    endtask

    task automatic next();
        @(negedge clk);
    endtask

    task automatic run_txn(input vec_t v);
        drive(1'b1, v.op, v.a, v.b, 1'b0, 1'b0, 64'd0);
        settle();
        chk("acc_stall", {63'd0, stall_o}, 64'd1);
        chk("acc_start", {63'd0, start}, 64'd0);
        chk("acc_flag", {63'd0, flag_m}, 64'd0);
        sb_q.push_back(v.res);
        next();
        if (v.hit) begin
            idle_in();
            settle();
            chk("hit_flag", {63'd0, flag_m}, 64'd1);
            chk("hit_start", {63'd0, start}, 64'd0);
            chk("hit_stall", {63'd0, stall_o}, 64'd0);
            chk("hit_mul_a", {32'd0, mul_a}, {32'd0, v.a});
            next();
        end else begin
            for (int k = 0; k <= v.dly; k++) begin
                drive(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, (k == v.dly), v.prod);
                settle();
                chk("wait_stall", {63'd0, stall_o}, 64'd1);
                chk("wait_start", {63'd0, start}, {63'd0, (k == 0)});
                chk("wait_flag", {63'd0, flag_m}, 64'd0);
                if (k == 0) begin
                    chk("miss_mul_a", {32'd0, mul_a}, {32'd0, v.a});
                    chk("miss_mul_b", {32'd0, mul_b}, {32'd0, v.b});
                    chk("miss_mul_op", {62'd0, mul_op}, {62'd0, v.op});
                end
                next();
            end
            idle_in();
            settle();
            chk("drain_flag", {63'd0, flag_m}, 64'd1);
            chk("drain_stall", {63'd0, stall_o}, 64'd0);
            chk("drain_start", {63'd0, start}, 64'd0);
            next();
        end
        settle();
        chk("post_flag", {63'd0, flag_m}, 64'd0);
        chk("post_result_hold", {32'd0, result_m}, {32'd0, v.res});
        next();
    endtask

    initial begin
        vecs[0] = '{2'b00, 32'd7,          32'd6,          64'd42,                  3, 1'b0, 32'h0000002A};
        vecs[1] = '{2'b01, 32'hFFFFFFFF,   32'hFFFFFFFF,   64'h1,                   1, 1'b0, 32'h00000000};
        vecs[2] = '{2'b11, 32'hFFFFFFFF,   32'hFFFFFFFF,   64'hFFFFFFFE00000001,    0, 1'b0, 32'hFFFFFFFE};
        vecs[3] = '{2'b00, 32'hFFFFFFFF,   32'hFFFFFFFF,   64'h0,                   0, 1'b1, 32'h00000001};
        vecs[4] = '{2'b11, 32'hFFFFFFFF,   32'hFFFFFFFF,   64'h0,                   0, 1'b1, 32'hFFFFFFFE};
        vecs[5] = '{2'b10, 32'h80000000,   32'd2,          64'hFFFFFFFF00000000,    2, 1'b0, 32'hFFFFFFFF};
        vecs[6] = '{2'b00, 32'h12345678,   32'h10,         64'h0000000123456780,    1, 1'b0, 32'h23456780};

        // Reset: stall forced low while rst, all outputs cleared.
        rst = 1'b1;
        drive(1'b1, OP_MUL, 32'd7, 32'd6, 1'b0, 1'b0, 64'd0);
        next();
        settle();
        chk("rst_stall", {63'd0, stall_o}, 64'd0);
        chk("rst_start", {63'd0, start}, 64'd0);
        chk("rst_flag", {63'd0, flag_m}, 64'd0);
        chk("rst_timeout", {63'd0, timeout_err}, 64'd0);
        chk("rst_mul_a", {32'd0, mul_a}, 64'd0);
        chk("rst_mul_b", {32'd0, mul_b}, 64'd0);
        chk("rst_mul_op", {62'd0, mul_op}, 64'd0);
        chk("rst_result", {32'd0, result_m}, 64'd0);
        next();
        rst = 1'b0;
        idle_in();
        next();

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i]);
        end

        // Flush in WAIT cycle 2, done in WAIT cycle 5, MUL 3*5 waiting in ABORT.
        drive(1'b1, OP_MUL, 32'd9, 32'd9, 1'b0, 1'b0, 64'd0); settle(); next();
        idle_in(); settle();
        chk("ab_start", {63'd0, start}, 64'd1); next();
        settle(); next();
        drive(1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b0, 64'd0); settle();
        chk("ab_flush_stall", {63'd0, stall_o}, 64'd1); next();
        idle_in(); settle();
        chk("ab_stall_novalid", {63'd0, stall_o}, 64'd0); next();
        drive(1'b1, OP_MUL, 32'd3, 32'd5, 1'b0, 1'b0, 64'd0); settle();
        chk("ab_stall_valid", {63'd0, stall_o}, 64'd1);
        chk("ab_no_start", {63'd0, start}, 64'd0); next();
        drive(1'b1, OP_MUL, 32'd3, 32'd5, 1'b0, 1'b1, 64'd81); settle();
        chk("ab_done_stall", {63'd0, stall_o}, 64'd1); next();
        drive(1'b1, OP_MUL, 32'd3, 32'd5, 1'b0, 1'b0, 64'd0); settle();
        chk("ab_idle_stall", {63'd0, stall_o}, 64'd1);
        chk("ab_idle_start", {63'd0, start}, 64'd0);
        sb_q.push_back(32'h0000000F); next();
        idle_in(); settle();
        chk("ab2_start", {63'd0, start}, 64'd1);
        chk("ab2_mul_a", {32'd0, mul_a}, 64'd3);
        chk("ab2_mul_b", {32'd0, mul_b}, 64'd5); next();
        drive(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b1, 64'd15); settle(); next();
        idle_in(); settle();
        chk("ab2_flag", {63'd0, flag_m}, 64'd1); next();
        settle(); next();

        // flush and done together: product dropped, repeat must miss.
        drive(1'b1, OP_MUL, 32'd9, 32'd9, 1'b0, 1'b0, 64'd0); settle(); next();
        idle_in(); settle(); next();
        drive(1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b1, 64'd81); settle();
        chk("fd_stall", {63'd0, stall_o}, 64'd1); next();
        idle_in(); settle();
        chk("fd_no_flag", {63'd0, flag_m}, 64'd0); next();
        run_txn('{2'b00, 32'd9, 32'd9, 64'd81, 0, 1'b0, 32'h51});

        // Timeout: done never comes.
        drive(1'b1, OP_MUL, 32'd2, 32'd2, 1'b0, 1'b0, 64'd0); settle(); next();
        idle_in(); settle();
        chk("to_start", {63'd0, start}, 64'd1); next();
        for (int k = 0; k < 64; k++) begin
            settle();
            chk("to_wait_stall", {63'd0, stall_o}, 64'd1);
            if (k == 63) begin
                chk("to_not_yet", {63'd0, timeout_err}, 64'd0);
            end
            next();
        end
        settle();
        chk("to_err", {63'd0, timeout_err}, 64'd1);
        chk("to_stall", {63'd0, stall_o}, 64'd0);
        chk("to_flag", {63'd0, flag_m}, 64'd0);
        next();
        run_txn('{2'b00, 32'd9, 32'd9, 64'd81, 1, 1'b0, 32'h51});
        settle();
        chk("to_sticky", {63'd0, timeout_err}, 64'd1);
        next();

        // Reset in WAIT, then a stale done.
        drive(1'b1, OP_MUL, 32'd4, 32'd5, 1'b0, 1'b0, 64'd0); settle(); next();
        idle_in(); settle(); next();
        rst = 1'b1; settle();
        chk("rw_stall", {63'd0, stall_o}, 64'd0); next();
        rst = 1'b0; settle();
        chk("rw_start", {63'd0, start}, 64'd0);
        chk("rw_timeout", {63'd0, timeout_err}, 64'd0);
        chk("rw_mul_a", {32'd0, mul_a}, 64'd0);
        chk("rw_mul_op", {62'd0, mul_op}, 64'd0);
        chk("rw_result", {32'd0, result_m}, 64'd0);
        chk("rw_stall2", {63'd0, stall_o}, 64'd0);
        next();
        drive(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b1, 64'd20); settle(); next();
        idle_in(); settle();
        chk("rw_stale_flag", {63'd0, flag_m}, 64'd0); next();
        run_txn('{2'b00, 32'd4, 32'd5, 64'd20, 2, 1'b0, 32'h14});
        run_txn('{2'b00, 32'd4, 32'd5, 64'd0,  0, 1'b1, 32'h14});
        run_txn('{2'b01, 32'd4, 32'd5, 64'd20, 0, 1'b0, 32'h0});
        run_txn('{2'b00, 32'd4, 32'd5, 64'd0,  0, 1'b1, 32'h14});

        chk("sb_empty", {32'd0, 32'(sb_q.size())}, 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
